// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes and FSM encoding.
package alu_arbiter_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker; ptr names the winner when both request.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic ptr,
    output logic gnt_id,
    output logic gnt_valid
);

    always_comb begin
        gnt_valid = valid0 | valid1;
        gnt_id    = (valid0 && valid1) ? ptr : valid1;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two valid/ready requesters, one operation in flight.
// Handshake: a transfer happens on any cycle where valid && ready are both high.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_c,
    output logic             rsp0_zero,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_c,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_zero,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic             ptr;
    logic             id_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [OP_W-1:0]  op_r;
    logic [WIDTH-1:0] c_r;
    logic             zero_r;
    logic             gnt_id;
    logic             gnt_valid;
    logic             accept;
    logic             done;

    rr_arb2 u_arb (
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .ptr       (ptr),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Ready is gated by reset so nothing is granted while the block is being cleared.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (!reset && gnt_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    state_nxt  = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp0_valid = ~id_r;
                rsp1_valid = id_r;
                done       = id_r ? rsp1_ready : rsp0_ready;
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr    <= 1'b0;
            id_r   <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= '0;
            c_r    <= '0;
            zero_r <= 1'b0;
        end else begin
            if (accept) begin
                id_r <= gnt_id;
                a_r  <= gnt_id ? req1_a  : req0_a;
                b_r  <= gnt_id ? req1_b  : req0_b;
                op_r <= gnt_id ? req1_op : req0_op;
            end
            if (state == EXEC) begin
                c_r    <= alu_c;
                zero_r <= alu_zero;
            end
            // Fairness moves only when a response retires, not when a request is taken.
            if (done) ptr <= ~id_r;
        end
    end

    assign alu_a     = a_r;
    assign alu_b     = b_r;
    assign alu_op    = op_r;
    assign rsp0_c    = c_r;
    assign rsp0_zero = zero_r;
    assign rsp1_c    = c_r;
    assign rsp1_zero = zero_r;
    assign busy      = (state != IDLE);

endmodule
